// File: rtl/sfx_mixer.sv
// sfx_mixer: plays up to NUM_CH sample-ROM effects, mixing them once per SAMPLE_PERIOD onto Avalon-ST L/R sinks.
// Optional macro SFX_VOLUME_EN adds the ch_vol port for per-channel arithmetic-shift attenuation.
module sfx_mixer #(
    parameter int NUM_CH        = 2,
    parameter int SAMPLE_W      = 16,
    parameter int ADDR_W        = 15,
    parameter int SAMPLE_PERIOD = 285
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        start,
    input  logic [NUM_CH-1:0]        stop,
    input  logic [NUM_CH-1:0]        loop,
    input  logic [NUM_CH*ADDR_W-1:0] ch_len,
    input  logic                     mode,
`ifdef SFX_VOLUME_EN
    input  logic [3*NUM_CH-1:0]      ch_vol,
`endif
    output logic                     rom_rd,
    output logic [2:0]               rom_ch,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [SAMPLE_W-1:0]      rom_data,
    output logic [NUM_CH-1:0]        active,
    output logic [SAMPLE_W-1:0]      L_DATA,
    output logic [SAMPLE_W-1:0]      R_DATA,
    output logic                     L_VALID,
    output logic                     R_VALID,
    input  logic                     L_READY,
    input  logic                     R_READY,
    output logic [15:0]              drop_cnt
);

    localparam int TICK_W = $clog2(SAMPLE_PERIOD);
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W  = SAMPLE_W + 3;

    localparam logic [TICK_W-1:0]       TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);
    localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(NUM_CH - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX   = {{4{1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN   = {{4{1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ACC,
        S_OUT
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [TICK_W-1:0]       r_tick;
    logic                    w_tickLast;
    logic                    w_frameStart;
    logic [IDX_W-1:0]        r_idx;

    logic [NUM_CH-1:0]       r_active;
    logic [NUM_CH-1:0]       r_play;
    logic [NUM_CH-1:0]       r_pendStart;
    logic [NUM_CH-1:0]       r_pendStop;
    logic [ADDR_W-1:0]       r_pos [NUM_CH];
    logic [ADDR_W-1:0]       w_len [NUM_CH];

    logic [NUM_CH-1:0]       w_pendStart;
    logic [NUM_CH-1:0]       w_pendStop;
    logic [NUM_CH-1:0]       w_actApplied;
    logic [NUM_CH-1:0]       w_posClr;
    logic [NUM_CH-1:0]       w_playMask;
    logic                    w_fetchPlay;
    logic                    w_posLast;

    logic                    r_rdValid;
    logic signed [SAMPLE_W-1:0] w_sample;
    logic signed [ACC_W-1:0] w_sampleExt;
    logic signed [ACC_W-1:0] r_acc;
    logic [SAMPLE_W-1:0]     w_clamp;

    logic [SAMPLE_W-1:0]     r_lData;
    logic [SAMPLE_W-1:0]     r_rData;
    logic                    r_lValid;
    logic                    r_rValid;
    logic [15:0]             r_dropCnt;
    logic [1:0]              w_dropInc;
    logic [16:0]             w_dropSum;

    assign w_tickLast   = (r_tick == TICK_LAST);
    assign w_frameStart = (r_state == S_IDLE) && w_tickLast;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_len[i] = ch_len[i*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:  if (w_tickLast) w_stateNext = S_FETCH;
            S_FETCH: if (r_idx == LAST_IDX) w_stateNext = S_ACC;
            S_ACC:   w_stateNext = S_OUT;
            S_OUT:   w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_tick  <= w_tickLast ? '0 : r_tick + 1'b1;
            r_idx   <= (r_state == S_FETCH && w_stateNext == S_FETCH) ? r_idx + 1'b1 : '0;
        end
    end

    // Pulses arriving on the terminal-count cycle itself must still land in this frame.
    always_comb begin
        w_pendStart  = r_pendStart | start;
        w_pendStop   = r_pendStop | stop;
        w_actApplied = r_active;
        w_posClr     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_pendStart[i] && (w_len[i] != '0)) begin
                w_actApplied[i] = 1'b1;
                w_posClr[i]     = 1'b1;
            end else if (w_pendStop[i]) begin
                w_actApplied[i] = 1'b0;
            end
        end
        w_playMask = w_actApplied;
        if (mode) begin
            w_playMask = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_actApplied[i]) begin
                    w_playMask    = '0;
                    w_playMask[i] = 1'b1;
                end
            end
        end
    end

    assign w_fetchPlay = (r_state == S_FETCH) && r_play[r_idx];
    assign w_posLast   = ({1'b0, r_pos[r_idx]} + 1'b1) >= {1'b0, w_len[r_idx]};

    assign rom_rd   = w_fetchPlay;
    assign rom_ch   = w_fetchPlay ? 3'(r_idx) : 3'd0;
    assign rom_addr = w_fetchPlay ? r_pos[r_idx] : '0;
    assign active   = r_active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active    <= '0;
            r_play      <= '0;
            r_pendStart <= '0;
            r_pendStop  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_pos[i] <= '0;
            end
        end else if (w_frameStart) begin
            r_pendStart <= '0;
            r_pendStop  <= '0;
            r_active    <= w_actApplied;
            r_play      <= w_playMask;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_posClr[i]) r_pos[i] <= '0;
            end
        end else begin
            r_pendStart <= w_pendStart;
            r_pendStop  <= w_pendStop;
            if (w_fetchPlay) begin
                if (w_posLast) begin
                    if (loop[r_idx]) r_pos[r_idx] <= '0;
                    else             r_active[r_idx] <= 1'b0;
                end else begin
                    r_pos[r_idx] <= r_pos[r_idx] + 1'b1;
                end
            end
        end
    end

`ifdef SFX_VOLUME_EN
    logic [IDX_W-1:0] r_rdIdx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rdIdx <= '0;
        else          r_rdIdx <= r_idx;
    end

    assign w_sample = $signed(rom_data) >>> ch_vol[3*r_rdIdx +: 3];
`else
    assign w_sample = $signed(rom_data);
`endif

    assign w_sampleExt = {{3{w_sample[SAMPLE_W-1]}}, w_sample};

    // ROM data lags its strobe by one clock, so the last channel lands during ACC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdValid <= 1'b0;
            r_acc     <= '0;
        end else begin
            r_rdValid <= w_fetchPlay;
            if (r_state == S_IDLE)  r_acc <= '0;
            else if (r_rdValid)     r_acc <= r_acc + w_sampleExt;
        end
    end

    always_comb begin
        if (r_acc > SAT_MAX)      w_clamp = SAT_MAX[SAMPLE_W-1:0];
        else if (r_acc < SAT_MIN) w_clamp = SAT_MIN[SAMPLE_W-1:0];
        else                      w_clamp = r_acc[SAMPLE_W-1:0];
    end

    assign w_dropInc = {1'b0, (r_state == S_OUT) && r_lValid && !L_READY}
                     + {1'b0, (r_state == S_OUT) && r_rValid && !R_READY};
    assign w_dropSum = {1'b0, r_dropCnt} + {15'd0, w_dropInc};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lData   <= '0;
            r_rData   <= '0;
            r_lValid  <= 1'b0;
            r_rValid  <= 1'b0;
            r_dropCnt <= '0;
        end else begin
            if (r_state == S_OUT) begin
                r_lData  <= w_clamp;
                r_lValid <= 1'b1;
            end else if (r_lValid && L_READY) begin
                r_lValid <= 1'b0;
            end
            if (r_state == S_OUT) begin
                r_rData  <= w_clamp;
                r_rValid <= 1'b1;
            end else if (r_rValid && R_READY) begin
                r_rValid <= 1'b0;
            end
            r_dropCnt <= w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
        end
    end

    assign L_DATA   = r_lData;
    assign R_DATA   = r_rData;
    assign L_VALID  = r_lValid;
    assign R_VALID  = r_rValid;
    assign drop_cnt = r_dropCnt;

endmodule
